// File: rtl/huffman_job_ctrl_if.sv
// Huffman job controller bus bundle.
// Host job/source handshake, encoder link and code-table write port.
interface huffman_job_ctrl_if #(
   parameter int bit_width = 7
);
   logic                   i_start;
   logic [10:0]            i_job_len;
   logic                   i_src_valid;
   logic [bit_width:0]     i_src_data;
   logic                   o_src_ready;
   logic                   o_enc_clear;
   logic [bit_width:0]     o_enc_data_in;
   logic                   o_enc_data_enable;
   logic                   i_enc_out_state;
   logic [bit_width:0]     i_enc_symbol;
   logic [3:0]             i_enc_length;
   logic [2*bit_width+2:0] i_enc_code;
   logic                   o_tbl_we;
   logic [bit_width:0]     o_tbl_addr;
   logic [2*bit_width+6:0] o_tbl_wdata;
   logic [bit_width+1:0]   o_sym_count;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_error;

   modport master (
      output i_start, i_job_len, i_src_valid, i_src_data,
      output i_enc_out_state, i_enc_symbol, i_enc_length, i_enc_code,
      input  o_src_ready, o_enc_clear, o_enc_data_in, o_enc_data_enable,
      input  o_tbl_we, o_tbl_addr, o_tbl_wdata, o_sym_count,
      input  o_busy, o_done, o_error
   );

   modport slave (
      input  i_start, i_job_len, i_src_valid, i_src_data,
      input  i_enc_out_state, i_enc_symbol, i_enc_length, i_enc_code,
      output o_src_ready, o_enc_clear, o_enc_data_in, o_enc_data_enable,
      output o_tbl_we, o_tbl_addr, o_tbl_wdata, o_sym_count,
      output o_busy, o_done, o_error
   );
endinterface

// File: rtl/huffman_job_ctrl.sv
// Huffman job controller: buffers a job, clears the encoder,
// replays it as one gap-free burst and captures the code table.
module huffman_job_ctrl #(
   parameter int bit_width      = 7,
   parameter int length_of_Data = 1024,
   parameter int clear_cycles   = 2,
   parameter int timeout_cycles = 65535
) (
   input logic               i_clock,
   input logic               i_rst,
   huffman_job_ctrl_if.slave bus
);
   localparam int AW = $clog2(length_of_Data);
   localparam int TW = $clog2(timeout_cycles + clear_cycles + 2);
   localparam int SW = bit_width + 2;
   localparam int DW = bit_width + 1;
   localparam int WW = 2*bit_width + 7;
   localparam logic [SW-1:0] MAXSYM = SW'(2**(bit_width+1));

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CLEAR, S_BURST, S_WAIT, S_CAPTURE, S_DONE
   } state_t;

   state_t        r_state, w_state_n;
   logic [10:0]   r_len, w_len_n;
   logic [10:0]   r_cnt, w_cnt_n;
   logic [TW-1:0] r_timer, w_timer_n;
   logic          r_src_ready, w_src_ready_n;
   logic          r_enc_clear, w_enc_clear_n;
   logic          r_enc_en, w_enc_en_n;
   logic [DW-1:0] r_enc_data, w_enc_data_n;
   logic          r_tbl_we, w_tbl_we_n;
   logic [DW-1:0] r_tbl_addr, w_tbl_addr_n;
   logic [WW-1:0] r_tbl_wdata, w_tbl_wdata_n;
   logic [SW-1:0] r_sym_count, w_sym_count_n;
   logic          r_busy, w_busy_n;
   logic          r_done, w_done_n;
   logic          r_error, w_error_n;

   logic [DW-1:0] r_buf [length_of_Data];

   logic          w_len_ok;
   logic          w_src_fire;
   logic [10:0]   w_cnt_inc;
   logic [TW-1:0] w_timer_inc;
   logic          w_entry;
   logic          w_room;
   logic [AW-1:0] w_rd_addr;
   logic [DW-1:0] w_rd_data;

   assign w_len_ok    = (bus.i_job_len != 11'd0) &&
                        (bus.i_job_len <= 11'(length_of_Data));
   assign w_src_fire  = bus.i_src_valid & r_src_ready;
   assign w_cnt_inc   = r_cnt + 11'd1;
   assign w_timer_inc = r_timer + TW'(1);
   assign w_entry     = bus.i_enc_out_state && (bus.i_enc_length != 4'd0);
   assign w_room      = r_sym_count < MAXSYM;
   assign w_rd_addr   = (r_state == S_BURST) ? AW'(w_cnt_inc) : '0;
   assign w_rd_data   = r_buf[w_rd_addr];

   // job buffer fill, one byte per accepted source beat
   always_ff @(posedge i_clock) begin
      if (w_src_fire) r_buf[AW'(r_cnt)] <= bus.i_src_data;
   end

   // state and registered outputs
   always_ff @(posedge i_clock or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_cnt       <= '0;
         r_timer     <= '0;
         r_src_ready <= 1'b0;
         r_enc_clear <= 1'b0;
         r_enc_en    <= 1'b0;
         r_enc_data  <= '0;
         r_tbl_we    <= 1'b0;
         r_tbl_addr  <= '0;
         r_tbl_wdata <= '0;
         r_sym_count <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_len       <= w_len_n;
         r_cnt       <= w_cnt_n;
         r_timer     <= w_timer_n;
         r_src_ready <= w_src_ready_n;
         r_enc_clear <= w_enc_clear_n;
         r_enc_en    <= w_enc_en_n;
         r_enc_data  <= w_enc_data_n;
         r_tbl_we    <= w_tbl_we_n;
         r_tbl_addr  <= w_tbl_addr_n;
         r_tbl_wdata <= w_tbl_wdata_n;
         r_sym_count <= w_sym_count_n;
         r_busy      <= w_busy_n;
         r_done      <= w_done_n;
         r_error     <= w_error_n;
      end
   end

   // next-state and next-output decode
   always_comb begin
      w_state_n     = r_state;
      w_len_n       = r_len;
      w_cnt_n       = r_cnt;
      w_timer_n     = r_timer;
      w_src_ready_n = 1'b0;
      w_enc_clear_n = 1'b0;
      w_enc_en_n    = 1'b0;
      w_enc_data_n  = r_enc_data;
      w_tbl_we_n    = 1'b0;
      w_tbl_addr_n  = r_tbl_addr;
      w_tbl_wdata_n = r_tbl_wdata;
      w_sym_count_n = r_sym_count;
      w_busy_n      = 1'b1;
      w_done_n      = 1'b0;
      w_error_n     = r_error;
      unique case (r_state)
         S_IDLE: begin
            w_busy_n = 1'b0;
            if (bus.i_start && w_len_ok) begin
               w_len_n       = bus.i_job_len;
               w_cnt_n       = '0;
               w_error_n     = 1'b0;
               w_sym_count_n = '0;
               w_busy_n      = 1'b1;
               w_src_ready_n = 1'b1;
               w_state_n     = S_LOAD;
            end else if (bus.i_start) begin
               w_error_n = 1'b1;
               w_done_n  = 1'b1;
            end
         end
         S_LOAD: begin
            w_src_ready_n = 1'b1;
            if (w_src_fire) begin
               w_cnt_n = w_cnt_inc;
               if (w_cnt_inc == r_len) begin
                  w_src_ready_n = 1'b0;
                  w_enc_clear_n = 1'b1;
                  w_timer_n     = '0;
                  w_state_n     = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            w_enc_clear_n = 1'b1;
            w_timer_n     = w_timer_inc;
            if (w_timer_inc == TW'(clear_cycles)) begin
               w_enc_clear_n = 1'b0;
               w_cnt_n       = '0;
               w_enc_en_n    = 1'b1;
               w_enc_data_n  = w_rd_data;
               w_state_n     = S_BURST;
            end
         end
         S_BURST: begin
            if (w_cnt_inc == r_len) begin
               w_timer_n = '0;
               w_state_n = S_WAIT;
            end else begin
               w_cnt_n      = w_cnt_inc;
               w_enc_en_n   = 1'b1;
               w_enc_data_n = w_rd_data;
            end
         end
         S_WAIT, S_CAPTURE: begin
            // the entry presented with the rising enc_out_state is
            // captured too, so WAIT shares the capture path
            if (bus.i_enc_out_state) begin
               w_state_n = S_CAPTURE;
               w_timer_n = (r_state == S_WAIT) ? '0 : w_timer_inc;
               if (w_entry && w_room) begin
                  w_tbl_we_n    = 1'b1;
                  w_tbl_addr_n  = bus.i_enc_symbol;
                  w_tbl_wdata_n = {bus.i_enc_length, bus.i_enc_code};
                  w_sym_count_n = r_sym_count + SW'(1);
                  w_timer_n     = '0;
               end else if (w_entry) begin
                  w_error_n = 1'b1;
               end
               if (w_timer_n == TW'(timeout_cycles)) begin
                  w_error_n = 1'b1;
                  w_done_n  = 1'b1;
                  w_state_n = S_DONE;
               end
            end else if (r_state == S_CAPTURE) begin
               w_done_n  = 1'b1;
               w_state_n = S_DONE;
            end else begin
               w_timer_n = w_timer_inc;
               if (w_timer_inc == TW'(timeout_cycles)) begin
                  w_error_n = 1'b1;
                  w_done_n  = 1'b1;
                  w_state_n = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_busy_n  = 1'b0;
            w_state_n = S_IDLE;
         end
         default: begin
            w_busy_n  = 1'b0;
            w_state_n = S_IDLE;
         end
      endcase
   end

   assign bus.o_src_ready       = r_src_ready;
   assign bus.o_enc_clear       = r_enc_clear;
   assign bus.o_enc_data_in     = r_enc_data;
   assign bus.o_enc_data_enable = r_enc_en;
   assign bus.o_tbl_we          = r_tbl_we;
   assign bus.o_tbl_addr        = r_tbl_addr;
   assign bus.o_tbl_wdata       = r_tbl_wdata;
   assign bus.o_sym_count       = r_sym_count;
   assign bus.o_busy            = r_busy;
   assign bus.o_done            = r_done;
   assign bus.o_error           = r_error;
endmodule

// File: tb/tb_huffman_job_ctrl.sv
// Directed bench for huffman_job_ctrl.
// Job vectors from a table plus hand-written corner sequences.
module tb_huffman_job_ctrl;
   localparam int BW = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   huffman_job_ctrl_if #(.bit_width(BW)) bus();

   huffman_job_ctrl #(
      .bit_width(BW), .length_of_Data(1024),
      .clear_cycles(2), .timeout_cycles(16)
   ) dut (
      .i_clock(clk),
      .i_rst(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic [10:0]      len;
      bit               gappy;
      bit               legal;
      logic [7:0][7:0]  src;
      int               n_ent;
      logic [4:0][7:0]  esym;
      logic [4:0][3:0]  elen;
      logic [4:0][16:0] ecode;
      int               exp_sym;
      bit               exp_err;
   } vec_t;

   vec_t vecs[5];

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  g_src [1024];
   logic [7:0]  g_esym [300];
   logic [3:0]  g_elen [300];
   logic [16:0] g_ecode [300];
   int          g_n_ent;

   // output monitor, sampled on the falling edge
   int m_en = 0, m_runs = 0, m_falls = 0, m_clr = 0, m_done = 0;
   int m_rdy = 0, m_busy = 0, m_low = 0, m_done_off = -1;
   bit m_prev_en = 1'b0;
   logic [7:0]  m_bytes[$];
   logic [28:0] m_wr[$];

   always @(negedge clk) begin
      if (bus.o_enc_data_enable) begin
         m_en++;
         m_bytes.push_back(bus.o_enc_data_in);
         if (!m_prev_en) m_runs++;
      end else if (m_prev_en) begin
         m_falls++;
         m_low = 0;
      end else begin
         m_low++;
      end
      m_prev_en = bus.o_enc_data_enable;
      if (bus.o_enc_clear) m_clr++;
      if (bus.o_src_ready) m_rdy++;
      if (bus.o_busy) m_busy++;
      if (bus.o_done) begin
         m_done++;
         m_done_off = m_low;
      end
      if (bus.o_tbl_we) m_wr.push_back({bus.o_tbl_addr, bus.o_tbl_wdata});
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic logic any_out();
      return |{bus.o_src_ready, bus.o_enc_clear, bus.o_enc_data_in,
               bus.o_enc_data_enable, bus.o_tbl_we, bus.o_tbl_addr,
               bus.o_tbl_wdata, bus.o_sym_count, bus.o_busy,
               bus.o_done, bus.o_error};
   endfunction

   function automatic vec_t mk(
      input logic [10:0] len, input bit gappy, input bit legal,
      input logic [63:0] src, input int n_ent, input logic [39:0] esym,
      input logic [19:0] elen, input logic [84:0] ecode,
      input int exp_sym, input bit exp_err);
      vec_t v;
      v.len = len; v.gappy = gappy; v.legal = legal; v.src = src;
      v.n_ent = n_ent; v.esym = esym; v.elen = elen; v.ecode = ecode;
      v.exp_sym = exp_sym; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic send_bytes(input int len, input bit gappy,
                             input string tag);
      bit acc;
      for (int i = 0; i < len; i++) begin
         bus.i_src_valid = 1'b1;
         bus.i_src_data  = g_src[i];
         acc = 1'b0;
         for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = bus.o_src_ready;
            @(posedge clk); #1;
         end
         bus.i_src_valid = 1'b0;
         if (!acc) begin
            chk({tag, ".src_accept"}, 0, 1);
            break;
         end
         if (gappy) repeat (2) begin @(posedge clk); #1; end
      end
   endtask

   task automatic do_job(input logic [10:0] len, input bit gappy,
                         input bit legal, input bit poke,
                         input int exp_sym, input bit exp_err,
                         input string tag);
      int en0, run0, fal0, clr0, dn0, rdy0, bsy0, wr0, by0;
      int t, lat, bad, nexp;
      logic [28:0] ew;
      en0 = m_en; run0 = m_runs; fal0 = m_falls; clr0 = m_clr;
      dn0 = m_done; rdy0 = m_rdy; bsy0 = m_busy;
      wr0 = m_wr.size(); by0 = m_bytes.size();
      @(posedge clk); #1;
      bus.i_start   = 1'b1;
      bus.i_job_len = len;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      if (poke) begin
         bus.i_start   = 1'b1;
         bus.i_job_len = 11'd5;
         @(posedge clk); #1;
         bus.i_start = 1'b0;
      end
      if (legal) begin
         send_bytes(int'(len), gappy, tag);
         t = 0;
         while (m_falls == fal0 && t < 3000) begin
            @(posedge clk); t++;
         end
         #1;
         repeat (2) begin @(posedge clk); #1; end
         for (int i = 0; i < g_n_ent; i++) begin
            bus.i_enc_out_state = 1'b1;
            bus.i_enc_symbol    = g_esym[i];
            bus.i_enc_length    = g_elen[i];
            bus.i_enc_code      = g_ecode[i];
            @(posedge clk); #1;
         end
         bus.i_enc_out_state = 1'b0;
      end
      lat = 0;
      while (m_done == dn0 && lat < 200) begin
         @(posedge clk); lat++;
      end
      #1;
      chk({tag, ".done_pulses"}, m_done - dn0, 1);
      chk({tag, ".sym_count"}, bus.o_sym_count, exp_sym);
      chk({tag, ".error"}, bus.o_error, exp_err);
      chk({tag, ".busy_after"}, bus.o_busy, 0);
      chk({tag, ".en_cycles"}, m_en - en0, legal ? int'(len) : 0);
      chk({tag, ".en_runs"}, m_runs - run0, legal ? 1 : 0);
      chk({tag, ".clear_cycles"}, m_clr - clr0, legal ? 2 : 0);
      bad = 0;
      if (legal) begin
         for (int i = 0; i < int'(len); i++) begin
            if (by0 + i >= m_bytes.size()) bad++;
            else if (m_bytes[by0 + i] !== g_src[i]) bad++;
         end
      end
      chk({tag, ".burst_bytes"}, bad, 0);
      nexp = 0;
      bad  = 0;
      for (int i = 0; i < g_n_ent; i++) begin
         if (g_elen[i] != 4'd0 && nexp < 256) begin
            ew = {g_esym[i], g_elen[i], g_ecode[i]};
            if (wr0 + nexp >= m_wr.size()) bad++;
            else if (m_wr[wr0 + nexp] !== ew) bad++;
            nexp++;
         end
      end
      chk({tag, ".tbl_writes"}, m_wr.size() - wr0, nexp);
      chk({tag, ".tbl_data"}, bad, 0);
      if (!legal) begin
         chk({tag, ".done_latency"}, lat, 1);
         chk({tag, ".src_ready"}, m_rdy - rdy0, 0);
         chk({tag, ".busy"}, m_busy - bsy0, 0);
      end
   endtask

   task automatic run_vec(input int idx, input string tag);
      vec_t v;
      v = vecs[idx];
      for (int i = 0; i < 8; i++) g_src[i] = v.src[i];
      g_n_ent = v.n_ent;
      for (int i = 0; i < v.n_ent; i++) begin
         g_esym[i]  = v.esym[i];
         g_elen[i]  = v.elen[i];
         g_ecode[i] = v.ecode[i];
      end
      do_job(v.len, v.gappy, v.legal, 1'b0, v.exp_sym, v.exp_err, tag);
   endtask

   initial begin
      int en0, dn0, t;
      vecs[0] = mk(11'd4, 0, 1, 64'h41_42_42_41, 2, 40'h42_41, 20'h00011,
                   {17'd0, 17'd0, 17'd0, 17'd1, 17'd0}, 2, 0);
      vecs[1] = mk(11'd5, 1, 1, 64'h4F_4C_4C_45_48, 5,
                   40'h00_4F_4C_45_48, 20'h03132,
                   {17'd0, 17'd7, 17'd0, 17'd6, 17'd2}, 4, 0);
      vecs[2] = mk(11'd0, 0, 0, 64'h0, 0, 40'h0, 20'h0, 85'h0, 4, 1);
      vecs[3] = mk(11'd1025, 0, 0, 64'h0, 0, 40'h0, 20'h0, 85'h0, 4, 1);
      vecs[4] = mk(11'd1, 0, 1, 64'h5A, 1, 40'h5A, 20'h1, 85'h0, 1, 0);

      bus.i_start = 0; bus.i_job_len = 0;
      bus.i_src_valid = 0; bus.i_src_data = 0;
      bus.i_enc_out_state = 0; bus.i_enc_symbol = 0;
      bus.i_enc_length = 0; bus.i_enc_code = 0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.outs_zero", any_out(), 0);
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) run_vec(v, $sformatf("vec%0d", v));

      g_src[0] = 8'h61; g_src[1] = 8'h62; g_src[2] = 8'h63;
      g_n_ent = 0;
      do_job(11'd3, 0, 1, 0, 0, 1, "timeout");
      chk("timeout.offset_ok",
          (m_done_off >= 16 && m_done_off <= 17) ? 1 : 0, 1);

      g_src[0] = 8'h77; g_src[1] = 8'h78;
      g_src[2] = 8'h79; g_src[3] = 8'h7A;
      @(posedge clk); #1;
      bus.i_start = 1'b1; bus.i_job_len = 11'd4;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      send_bytes(4, 0, "rstmid");
      en0 = m_en;
      t = 0;
      while (m_en - en0 < 2 && t < 100) begin
         @(negedge clk); #1; t++;
      end
      chk("rstmid.en_reached", m_en - en0, 2);
      rst_n = 1'b0;
      #1;
      chk("rstmid.outs_zero", any_out(), 0);
      dn0 = m_done;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      chk("rstmid.no_done", m_done - dn0, 0);
      chk("rstmid.busy", bus.o_busy, 0);
      run_vec(0, "after_rst");

      for (int i = 0; i < 1024; i++) g_src[i] = 8'(i);
      g_n_ent = 256;
      for (int i = 0; i < 256; i++) begin
         g_esym[i] = 8'(i); g_elen[i] = 4'd8; g_ecode[i] = 17'(i);
      end
      do_job(11'd1024, 0, 1, 1, 256, 0, "max");

      g_n_ent = 257;
      for (int i = 0; i < 257; i++) begin
         g_esym[i] = 8'(i); g_elen[i] = 4'd8; g_ecode[i] = 17'(i);
      end
      do_job(11'd2, 0, 1, 0, 256, 1, "overflow");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/huffman_job_ctrl.md
Name: huffman_job_ctrl

Overview:
- Job-level sequencer in front of the Huffman encoder.
- Buffers one job of source bytes, clears the encoder, then replays the job as one gap-free data_enable burst (the encoder ends frequency counting on the first low enable cycle).
- Waits for the code table and writes each {symbol, length, code} entry into a symbol-indexed code-table RAM.
- Reports busy/done/error to the host.

Parameters:
- bit_width, 7, symbol MSB index (symbol is bit_width+1 bits).
- length_of_Data, 1024, maximum job length in symbols (buffer depth).
- clear_cycles, 2, cycles enc_clear is held high before a burst.
- timeout_cycles, 65535, maximum cycles from end of burst to first table entry, and also between table entries.

Ports:
- clock  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- job_len  in  11  job length in symbols, latched on start.
- src_valid  in  1  source byte valid.
- src_data  in  bit_width+1  source byte.
- src_ready  out  1  controller accepts src_data.
- enc_clear  out  1  encoder clear request, high for clear_cycles.
- enc_data_in  out  bit_width+1  byte to encoder.
- enc_data_enable  out  1  encoder data enable.
- enc_out_state  in  1  encoder table-output active.
- enc_symbol  in  bit_width+1  encoder output symbol.
- enc_length  in  4  encoder output code length.
- enc_code  in  2*bit_width+3  encoder output codeword.
- tbl_we  out  1  code-table write strobe.
- tbl_addr  out  bit_width+1  table address (= symbol).
- tbl_wdata  out  2*bit_width+7  {length[3:0], code}.
- sym_count  out  bit_width+2  table entries written this job.
- busy  out  1  job in progress.
- done  out  1  one-cycle end-of-job pulse.
- error  out  1  sticky job error; cleared on next accepted start.

Behaviour:
- All outputs are registered. Reset value of every output is 0; state returns to IDLE; the byte counter, timer and sym_count clear. Buffer contents are don't-care after reset.
- A reset mid-job aborts immediately. No done pulse is generated.
- IDLE:
  - busy=0.
  - On start with 1 ≤ job_len ≤ length_of_Data: latch job_len, clear error and sym_count, go to LOAD.
  - On start with job_len=0 or job_len>length_of_Data: set error, pulse done next cycle, stay IDLE.
- LOAD:
  - src_ready=1 while count<job_len.
  - Each cycle with src_valid&src_ready: write buffer[count], count++.
  - When count reaches job_len: src_ready drops the same edge; go to CLEAR.
  - Back-pressure is allowed; source gaps are absorbed here.
- CLEAR: enc_clear=1 for exactly clear_cycles cycles, then go to BURST with count=0.
- BURST:
  - enc_data_enable=1 and enc_data_in=buffer[count] for exactly job_len consecutive cycles, with no bubbles.
  - The bytes come out in arrival order.
  - Next cycle: enable=0, go to WAIT_TABLE.
- WAIT_TABLE:
  - The timer counts up.
  - On enc_out_state=1, go to CAPTURE and reset the timer.
  - On timer=timeout_cycles: set error, go to DONE.
- CAPTURE:
  - Each cycle with enc_out_state=1 and enc_length≠0: tbl_we=1, tbl_addr=enc_symbol, tbl_wdata={enc_length, enc_code}, sym_count++. The write is registered, so there is 1 cycle of latency.
  - Entries with enc_length=0 are skipped (no write).
  - The timer resets on each write.
  - If sym_count would exceed 2^(bit_width+1): set error and do not write.
  - When enc_out_state falls, go to DONE.
  - If the timer expires while enc_out_state stays high, set error and go to DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, then IDLE. sym_count and error hold until the next start.
- busy=1 in every state except IDLE.
- start outside IDLE is ignored.
- src_valid outside LOAD is ignored (src_ready=0).
- Byte count width is 11 bits, so job_len=1024 is legal and does not wrap.

Test Plan:
- Single job:
  - Stimulus: start, job_len=4, bytes "ABBA" with no gaps; encoder model returns entries (A,1,0b0) and (B,1,0b1).
  - Response: enc_clear high 2 cycles; enc_data_enable high exactly 4 consecutive cycles carrying A,B,B,A; tbl writes addr 0x41 wdata {1,0} and addr 0x42 wdata {1,1}; sym_count=2; one done pulse; error=0.
- Gappy source:
  - Stimulus: job_len=5, src_valid toggled 1-0-0-1-…
  - Response: LOAD absorbs the gaps; BURST still holds 5 unbroken enable cycles.
- Illegal length:
  - Stimulus: start with job_len=0, then with job_len=1025.
  - Response: no enable and no src_ready; error=1 and done pulse one cycle after each start; busy stays 0.
- Timeout:
  - Stimulus: job_len=3; encoder never raises enc_out_state; timeout_cycles=16.
  - Response: 16 cycles after the burst, error=1 and done pulses; sym_count=0.
- Reset mid-BURST:
  - Stimulus: drop rst at the 2nd enable cycle.
  - Response: enable, busy and all outputs are 0 asynchronously; no done pulse; a subsequent start runs a clean job.
- Max job:
  - Stimulus: job_len=1024, 256 distinct symbols.
  - Response: 1024 consecutive enable cycles; 256 table writes; sym_count=256; no error; start during busy ignored.
